// File: rtl/sirv_qspi_pkg.sv
// ---------------------------------------------------------------------------
// sirv_qspi_pkg
// Shared constants and width helpers for the QSPI response-path blocks.
//   QSPI_BYTE_W : width of one rx byte on the link and the inner ports
//   idxWidth()  : bits needed to name one of n inner ports (at least 1)
//   cntWidth()  : bits needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package sirv_qspi_pkg;

  localparam int QSPI_BYTE_W = 8;

  // Owner indices need enough bits to encode every port, and never zero bits
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy has to reach DEPTH itself, hence the extra bit
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sirv_qspi_owner_fifo.sv
// ---------------------------------------------------------------------------
// sirv_qspi_owner_fifo
// Small synchronous FIFO that remembers, in order, which inner port owns each
// outstanding read-returning frame.
// Parameters: DEPTH (power of 2, >= 2), DATA_W (owner index width)
// Ports:
//   clock, rst_n : clock and asynchronous active-low reset
//   flush_i      : synchronous clear, overrides push and pop
//   push_i       : write data_i at the tail (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   data_i       : owner index to record
//   head_o       : owner index at the head
//   full_o       : occupancy == DEPTH
//   empty_o      : occupancy == 0
//   count_o      : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module sirv_qspi_owner_fifo
  import sirv_qspi_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 1
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [cntWidth(DEPTH)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pushOk;
  logic              popOk;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // Requests that would overflow or underflow are silently dropped here so the
  // pointers can never drift apart from the occupancy count
  assign pushOk = push_i & ~full_o;
  assign popOk  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (popOk)  rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(pushOk) - CNT_W'(popOk);
    end
  end

  // Pointer/count registers plus the storage array
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (pushOk && !flush_i) mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sirv_qspi_resp_router.sv
// ---------------------------------------------------------------------------
// sirv_qspi_resp_router
// Return-path partner of the QSPI link arbiter: records the owner of every
// fired tx frame that expects a read byte, then steers each rx byte from the
// link back to that owner, strictly in order.
// Optional feature macro: QSPI_RESP_ROUTER_TIMEOUT_EN (rx watchdog).
// Ports:
//   clock, rst_n      : clock and asynchronous active-low reset
//   flush             : synchronous clear of the owner FIFO and watchdog
//   tx_fire/tx_sel/tx_expect_rx : fired-frame record request
//   tx_stall          : owner FIFO full, arbiter must not fire
//   link_rx_valid/ready/data    : rx byte stream from the link
//   port_rx_valid/ready/data    : one-hot rx stream to the inner ports
//   outstanding       : owner FIFO occupancy
//   err_clr           : clears the sticky error flags
//   orphan_err        : sticky, rx byte arrived with no recorded owner
//   timeout_err       : sticky, watchdog dropped an entry (0 without feature)
// ---------------------------------------------------------------------------
module sirv_qspi_resp_router
  import sirv_qspi_pkg::*;
#(
  parameter int PORTS          = 2,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        tx_fire,
  input  logic [idxWidth(PORTS)-1:0]  tx_sel,
  input  logic                        tx_expect_rx,
  output logic                        tx_stall,
  input  logic                        link_rx_valid,
  output logic                        link_rx_ready,
  input  logic [QSPI_BYTE_W-1:0]      link_rx_data,
  output logic [PORTS-1:0]            port_rx_valid,
  input  logic [PORTS-1:0]            port_rx_ready,
  output logic [QSPI_BYTE_W-1:0]      port_rx_data,
  output logic [cntWidth(DEPTH)-1:0]  outstanding,
  input  logic                        err_clr,
  output logic                        orphan_err,
  output logic                        timeout_err
);

  localparam int IDX_W = idxWidth(PORTS);
  localparam logic [IDX_W:0] PORTS_L = (IDX_W+1)'(PORTS);

  logic             fifoFull;
  logic             fifoEmpty;
  logic [IDX_W-1:0] headSel;
  logic             pushReq;
  logic             popReq;
  logic             linkPop;
  logic             orphanSet;
  logic             orphanErr_q, orphanErr_d;

  // Only frames that bring a byte back and name a real port get an owner slot;
  // the extra top bit keeps the range check meaningful when PORTS is a power of 2
  assign pushReq = tx_fire & tx_expect_rx & ~fifoFull & ({1'b0, tx_sel} < PORTS_L);

  assign linkPop   = link_rx_valid & link_rx_ready & ~fifoEmpty;
  assign orphanSet = link_rx_valid & fifoEmpty;
  assign tx_stall  = fifoFull;

  sirv_qspi_owner_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (IDX_W)
  ) u_owner_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .data_i  (tx_sel),
    .head_o  (headSel),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (outstanding)
  );

  // Zero-latency steering: the head owner sees the link byte and drives the
  // link ready. With no owner the byte is swallowed so the link never stalls.
  always_comb begin
    port_rx_valid = '0;
    link_rx_ready = 1'b1;
    port_rx_data  = '0;
    if (!fifoEmpty) begin
      port_rx_data  = link_rx_data;
      link_rx_ready = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
        if (headSel == IDX_W'(p)) begin
          port_rx_valid[p] = link_rx_valid;
          link_rx_ready    = port_rx_ready[p];
        end
      end
    end
  end

  // Sticky orphan flag; a new orphan in the clearing cycle keeps it set
  always_comb begin
    orphanErr_d = orphanErr_q;
    if (orphanSet)    orphanErr_d = 1'b1;
    else if (err_clr) orphanErr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) orphanErr_q <= 1'b0;
    else        orphanErr_q <= orphanErr_d;
  end

  assign orphan_err = orphanErr_q;

`ifdef QSPI_RESP_ROUTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            wdFire;
  logic            timeoutErr_q, timeoutErr_d;

  // The watchdog only runs while someone is waiting on a byte that never comes;
  // a flush wins over a firing watchdog so no error is raised for a flushed entry
  assign wdFire = ~fifoEmpty & ~linkPop & ~flush & (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign popReq = linkPop | wdFire;

  always_comb begin
    wdCnt_d = wdCnt_q + WD_W'(1);
    if (flush || fifoEmpty || linkPop || wdFire) wdCnt_d = '0;
  end

  always_comb begin
    timeoutErr_d = timeoutErr_q;
    if (wdFire)       timeoutErr_d = 1'b1;
    else if (err_clr) timeoutErr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt_q      <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      wdCnt_q      <= wdCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign timeout_err = timeoutErr_q;
`else
  // Without the watchdog an entry stays until its byte arrives or a flush
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign popReq         = linkPop;
  assign timeout_err    = 1'b0;
`endif

endmodule
